// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the fetch/LSU memory arbiter.
package mem_arb_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic {REQ_FETCH, REQ_LSU} requester_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin picker; the requester not granted last wins a tie.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       fetch_valid,
  input  logic       lsu_valid,
  input  requester_t last_grant,
  output requester_t winner
);
  assign winner = (fetch_valid && (!lsu_valid || last_grant == REQ_LSU)) ? REQ_FETCH : REQ_LSU;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and LSU, one transaction in flight.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                fetch_valid,
  output logic                fetch_ready,
  input  logic [ADDR_W-1:0]   fetch_addr,
  output logic                fetch_rsp_valid,
  output logic [DATA_W-1:0]   fetch_rsp_rdata,
  output logic                fetch_rsp_err,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_we,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic [DATA_W-1:0]   lsu_wdata,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_rdata,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);
  state_t     state, next;
  requester_t winner, owner, last_grant;
  logic       idle, fetch_acc, lsu_acc, misalign, start, done;

  rr_arb2 u_rr (
    .fetch_valid(fetch_valid),
    .lsu_valid  (lsu_valid),
    .last_grant (last_grant),
    .winner     (winner)
  );

  assign idle        = state == IDLE;
  assign fetch_ready = idle && fetch_valid && winner == REQ_FETCH;
  assign lsu_ready   = idle && lsu_valid && winner == REQ_LSU;
  assign fetch_acc   = fetch_valid && fetch_ready;
  assign lsu_acc     = lsu_valid && lsu_ready;
  assign misalign    = fetch_acc && fetch_addr[1:0] != 2'b00;
  assign start       = lsu_acc || (fetch_acc && !misalign);
  // rvalid only counts while a transaction is outstanding; in IDLE it is stale
  assign done        = (state == REQ && mem_gnt && mem_rvalid) || (state == WAIT && mem_rvalid);
  assign mem_req     = state == REQ;

  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? REQ : IDLE;
      REQ:     next = mem_gnt ? (mem_rvalid ? IDLE : WAIT) : REQ;
      WAIT:    next = mem_rvalid ? IDLE : WAIT;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner           <= REQ_FETCH;
      last_grant      <= REQ_LSU;
      mem_addr        <= '0;
      mem_we          <= 1'b0;
      mem_wstrb       <= '0;
      mem_wdata       <= '0;
      fetch_rsp_valid <= 1'b0;
      fetch_rsp_err   <= 1'b0;
      fetch_rsp_rdata <= '0;
      lsu_rsp_valid   <= 1'b0;
      lsu_rsp_rdata   <= '0;
    end else begin
      fetch_rsp_valid <= misalign || (done && owner == REQ_FETCH);
      fetch_rsp_err   <= misalign;
      lsu_rsp_valid   <= done && owner == REQ_LSU;
      if (fetch_acc || lsu_acc) last_grant <= winner;
      if (start) begin
        owner     <= winner;
        mem_addr  <= lsu_acc ? lsu_addr : fetch_addr;
        mem_we    <= lsu_acc && lsu_we;
        mem_wstrb <= lsu_acc ? lsu_wstrb : '0;
        mem_wdata <= lsu_acc ? lsu_wdata : '0;
      end
      if (misalign) fetch_rsp_rdata <= '0;
      else if (done && owner == REQ_FETCH) fetch_rsp_rdata <= mem_rdata;
      if (done && owner == REQ_LSU) lsu_rsp_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized requesters and memory checked against a transaction-level model.
module tb_mem_arbiter;
  logic        clk = 1'b0, resetn;
  logic        fetch_valid, fetch_ready, fetch_rsp_valid, fetch_rsp_err;
  logic [31:0] fetch_addr, fetch_rsp_rdata;
  logic        lsu_valid, lsu_ready, lsu_we, lsu_rsp_valid;
  logic [3:0]  lsu_wstrb;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rsp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .resetn(resetn),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_addr(fetch_addr),
    .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_rdata(fetch_rsp_rdata), .fetch_rsp_err(fetch_rsp_err),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_we(lsu_we),
    .lsu_wstrb(lsu_wstrb), .lsu_wdata(lsu_wdata),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // transaction-level model: one outstanding access, tie goes to whoever was not last accepted
  bit          busy, in_wait, owner_l, last_l, exp_f, exp_l, exp_ferr, f_acc, l_acc, win_l;
  logic [31:0] exp_fd, exp_ld, m_addr, m_wdata;
  logic        m_we;
  logic [3:0]  m_wstrb;
  int          dly, pf, pl, pmis, pg, pr, pstale;

  task automatic model_reset();
    busy = 0; in_wait = 0; owner_l = 0; last_l = 1; exp_f = 0; exp_l = 0;
    f_acc = 0; l_acc = 0; dly = 0;
  endtask

  task automatic step();
    @(negedge clk);
    chk("fetch_rsp_valid", 32'(fetch_rsp_valid), 32'(exp_f));
    if (exp_f) begin
      chk("fetch_rsp_err", 32'(fetch_rsp_err), 32'(exp_ferr));
      chk("fetch_rsp_rdata", fetch_rsp_rdata, exp_fd);
    end
    chk("lsu_rsp_valid", 32'(lsu_rsp_valid), 32'(exp_l));
    if (exp_l) chk("lsu_rsp_rdata", lsu_rsp_rdata, exp_ld);
    chk("mem_req", 32'(mem_req), 32'(busy && !in_wait));
    if (busy && !in_wait) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (f_acc) fetch_valid = 0;
    if (l_acc) lsu_valid = 0;
    if (!fetch_valid && $urandom_range(99) < pf) begin
      fetch_valid = 1;
      fetch_addr = ($urandom & 32'h0000_FFFC) | (($urandom_range(99) < pmis) ? 32'($urandom_range(1, 3)) : 32'h0);
    end
    if (!lsu_valid && $urandom_range(99) < pl) begin
      lsu_valid = 1;
      lsu_addr  = $urandom & 32'h0000_FFFC;
      lsu_we    = 1'($urandom_range(1));
      lsu_wstrb = 4'($urandom_range(15));
      lsu_wdata = $urandom;
    end
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
    if (busy && !in_wait) begin
      mem_gnt = $urandom_range(99) < pg;
      if (mem_gnt) begin
        mem_rvalid = $urandom_range(99) < pr;
        dly = $urandom_range(1, 3);
      end
    end else if (in_wait) begin
      dly--;
      mem_rvalid = dly == 0;
    end else mem_rvalid = $urandom_range(99) < pstale;
    if (busy && mem_rvalid) mem_rdata = ram_word(m_addr);
    #1;
    win_l = (fetch_valid && lsu_valid) ? !last_l : lsu_valid;
    f_acc = !busy && fetch_valid && !win_l;
    l_acc = !busy && lsu_valid && win_l;
    if (fetch_valid) chk("fetch_ready", 32'(fetch_ready), 32'(f_acc));
    if (lsu_valid) chk("lsu_ready", 32'(lsu_ready), 32'(l_acc));
    exp_f = 0; exp_l = 0;
    if (busy && mem_rvalid) begin
      if (owner_l) begin exp_l = 1; exp_ld = ram_word(m_addr); end
      else begin exp_f = 1; exp_ferr = 0; exp_fd = ram_word(m_addr); end
      busy = 0; in_wait = 0;
    end else if (busy && mem_gnt) in_wait = 1;
    if (f_acc) begin
      last_l = 0;
      if (fetch_addr[1:0] != 2'b00) begin
        exp_f = 1; exp_ferr = 1; exp_fd = 0;
      end else begin
        busy = 1; owner_l = 0; m_addr = fetch_addr; m_we = 0; m_wstrb = 0; m_wdata = 0;
      end
    end
    if (l_acc) begin
      last_l = 1; busy = 1; owner_l = 1;
      m_addr = lsu_addr; m_we = lsu_we; m_wstrb = lsu_wstrb; m_wdata = lsu_wdata;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_fetch_rsp_valid"}, 32'(fetch_rsp_valid), 32'h0);
    chk({tag, "_fetch_rsp_err"}, 32'(fetch_rsp_err), 32'h0);
    chk({tag, "_fetch_rsp_rdata"}, fetch_rsp_rdata, 32'h0);
    chk({tag, "_lsu_rsp_valid"}, 32'(lsu_rsp_valid), 32'h0);
    chk({tag, "_lsu_rsp_rdata"}, lsu_rsp_rdata, 32'h0);
  endtask

  initial begin
    resetn = 0;
    fetch_valid = 0; fetch_addr = 0; lsu_valid = 0; lsu_addr = 0; lsu_we = 0;
    lsu_wstrb = 0; lsu_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    resetn = 1;
    // both requesters always pending, zero-wait memory: strict alternation
    pf = 100; pl = 100; pmis = 0; pg = 100; pr = 100; pstale = 0;
    repeat (40) step();
    // fetch only, with misaligned addresses
    pf = 70; pl = 0; pmis = 40;
    repeat (60) step();
    // fully random traffic, stalls and stale responses
    pf = 40; pl = 40; pmis = 20; pg = 50; pr = 50; pstale = 20;
    repeat (800) step();
    // reach WAIT, then reset mid-transaction
    pf = 0; pl = 100; pg = 100; pr = 0; pstale = 0;
    for (int i = 0; i < 200 && !in_wait; i++) step();
    chk("reached_wait", 32'(in_wait), 32'h1);
    resetn = 0; fetch_valid = 0; lsu_valid = 0; mem_gnt = 0; mem_rvalid = 0;
    #1;
    chk_reset_outputs("abort");
    chk("abort_fetch_ready", 32'(fetch_ready), 32'h0);
    @(negedge clk);
    resetn = 1;
    model_reset();
    pf = 0; pl = 0; pstale = 100;
    repeat (4) step();
    pf = 100; pmis = 0; pg = 100; pr = 100; pstale = 0;
    repeat (10) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the core's single memory port between instruction fetch and the load/store unit. One transaction in flight at a time; round-robin tie-break; response routed back to the owning requester. Sits between the core's step sequencer (fetch in step 1, memory access in step 4) and the unified RAM, and rejects misaligned fetches locally so the core can trap.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- fetch_valid / fetch_ready  in / out  1  fetch request handshake
- fetch_addr  in  ADDR_W  fetch byte address
- fetch_rsp_valid  out  1  one-cycle response pulse
- fetch_rsp_rdata  out  DATA_W  fetched word
- fetch_rsp_err  out  1  qualifies fetch_rsp_valid: misaligned fetch, no memory access
- lsu_valid / lsu_ready  in / out  1  LSU request handshake
- lsu_addr  in  ADDR_W; lsu_we  in  1; lsu_wstrb  in  DATA_W/8; lsu_wdata  in  DATA_W
- lsu_rsp_valid  out  1  one-cycle pulse (read data or write ack)
- lsu_rsp_rdata  out  DATA_W  read data; undefined for writes
- mem_req  out  1; mem_gnt  in  1  memory request/grant
- mem_addr  out  ADDR_W; mem_we  out  1; mem_wstrb  out  DATA_W/8; mem_wdata  out  DATA_W
- mem_rvalid  in  1; mem_rdata  in  DATA_W  memory response, one per granted request

## Operation
- States: IDLE, REQ, WAIT. Registers: state, owner (FETCH/LSU), last_grant, latched request fields, response outputs.
- IDLE: winner chosen combinationally. Only one valid -> it wins. Both valid -> requester not equal to last_grant wins.
- x_ready = (state==IDLE) && x is winner. ready is low in REQ/WAIT. Acceptance = valid && ready.
- Accepted LSU request or aligned fetch (fetch_addr[1:0]==0): latch addr/we/wstrb/wdata (fetch: we=0, wstrb=0), owner, last_grant<=winner; go REQ.
- Accepted misaligned fetch: no memory access; next cycle fetch_rsp_valid=1, fetch_rsp_err=1, rdata=0; stay IDLE; last_grant<=FETCH.
- REQ: mem_req=1, mem_* driven from latched registers (stable until granted). mem_gnt && mem_rvalid -> respond, IDLE. mem_gnt only -> WAIT.
- WAIT: mem_req=0. mem_rvalid -> capture mem_rdata into owner's rsp_rdata, pulse owner's rsp_valid next cycle, IDLE.
- mem_rvalid in IDLE is ignored (stale response after reset).
- Response pulse cycle is an IDLE cycle: a new request may be accepted in it.

## Timing
- Reset (async assert, sync deassert assumed upstream): state=IDLE, last_grant=LSU (fetch wins first tie), mem_req=0, mem_we=0, mem_addr/wdata/wstrb=0, both rsp_valid=0, rsp_err=0, rsp_rdata=0.
- Latency with zero-wait memory (gnt at first REQ cycle, rvalid same cycle): accept at cycle N, mem_req at N+1, rsp_valid at N+2.
- Each extra grant stall or response delay cycle adds one cycle.
- Misaligned fetch: accept N, error response N+1.
- Reset mid-transaction: aborts immediately, no response emitted; memory's later rvalid dropped.
- rsp_rdata holds its value until next response of same requester.

## Structure
- Package mem_arb_pkg: state enum {IDLE, REQ, WAIT}, requester enum {REQ_FETCH, REQ_LSU}, default widths.
- Sub-module rr_arb2: two-input round-robin picker (valids, last_grant -> winner), purely combinational; last_grant register lives in mem_arbiter.

## Test plan
- Single fetch, zero-wait memory, addr 0x100, mem_rdata 0x00000013 -> mem_req at N+1 with mem_addr 0x100, mem_we 0; fetch_rsp_valid at N+2, rdata 0x13, err 0.
- LSU write addr 0x204, wdata 0xDEADBEEF, wstrb 0xF, gnt delayed 2 cycles, rvalid 3 cycles after gnt -> mem_* stable through stall; lsu_rsp_valid one cycle after rvalid; fetch_rsp_valid never asserted.
- Both valid continuously from reset -> grants alternate FETCH, LSU, FETCH, LSU; each ready only on its turn.
- Fetch addr 0x102 -> fetch_rsp_err=1 one cycle later, mem_req never asserted, next request accepted same cycle as error pulse.
- Assert resetn low while in WAIT, then inject mem_rvalid after release -> no rsp_valid, all outputs at reset values, next fetch served normally.
